// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: one holding slot per execution unit,
// one registered broadcast per cycle, all in-flight results dropped on flush.
module cdb_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int ENTRY_WIDTH = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*ENTRY_WIDTH-1:0] req_entry,
    input  logic [N_REQ*DATA_WIDTH-1:0]  req_value,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         cdb_write,
    output logic [ENTRY_WIDTH-1:0]       cdb_entry,
    output logic [DATA_WIDTH-1:0]        cdb_value,
    output logic [1:0]                   cdb_src
);

    logic [N_REQ-1:0]       slot_full;
    logic [ENTRY_WIDTH-1:0] slot_entry [N_REQ];
    logic [DATA_WIDTH-1:0]  slot_value [N_REQ];
    logic [1:0]             rr_ptr;

    logic [N_REQ-1:0] grant;
    logic [1:0]       gidx;
    logic [1:0]       idx;
    logic             gvalid;

    // Search upward from rr_ptr; the first full slot wins. Flush suppresses any grant.
    always_comb begin
        grant  = '0;
        gidx   = rr_ptr;
        idx    = '0;
        gvalid = 1'b0;
        if (!flush) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                idx = rr_ptr + k[1:0];
                if (!gvalid && slot_full[idx]) begin
                    gvalid = 1'b1;
                    gidx   = idx;
                end
            end
        end
        if (gvalid) begin
            grant[gidx] = 1'b1;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            req_ready[i] = !flush && (!slot_full[i] || grant[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_full <= '0;
            rr_ptr    <= '0;
            cdb_write <= 1'b0;
            cdb_entry <= '0;
            cdb_value <= '0;
            cdb_src   <= '0;
        end else begin
            cdb_write <= gvalid;
            if (gvalid) begin
                rr_ptr    <= gidx + 2'd1;
                cdb_entry <= slot_entry[gidx];
                cdb_value <= slot_value[gidx];
                cdb_src   <= gidx;
            end
            // A refill in the same cycle as a grant keeps the slot full.
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (flush) begin
                    slot_full[i] <= 1'b0;
                end else if (req_valid[i] && req_ready[i]) begin
                    slot_full[i] <= 1'b1;
                end else if (grant[i]) begin
                    slot_full[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                slot_entry[i] <= req_entry[i*ENTRY_WIDTH +: ENTRY_WIDTH];
                slot_value[i] <= req_value[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a reference model predicts each cycle's bus
// contents and handshakes; a monitor pops predictions and compares the registered outputs.
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int EW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [N-1:0]    req_valid;
    logic [N*EW-1:0] req_entry;
    logic [N*DW-1:0] req_value;
    logic [N-1:0]    req_ready;
    logic            cdb_write;
    logic [EW-1:0]   cdb_entry;
    logic [DW-1:0]   cdb_value;
    logic [1:0]      cdb_src;

    always #5 clk = ~clk;

    cdb_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .ENTRY_WIDTH(EW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_entry(req_entry), .req_value(req_value),
        .req_ready(req_ready),
        .cdb_write(cdb_write), .cdb_entry(cdb_entry), .cdb_value(cdb_value),
        .cdb_src(cdb_src)
    );

    typedef struct {
        bit          w;
        bit [EW-1:0] e;
        bit [DW-1:0] v;
        bit [1:0]    s;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: which units hold a buffered result, and the bus contents.
    bit          m_full [N];
    int          m_e    [N];
    bit [DW-1:0] m_v    [N];
    int          m_ptr;
    exp_t        m_out;

    // Producer side: each unit's result waiting to be accepted.
    bit          pend [N];
    int          pe   [N];
    bit [DW-1:0] pv   [N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input bit r, input bit f);
        int      g;
        bit [N-1:0] rdy;
        exp_t    nx;
        rst   = r;
        flush = f;
        for (int i = 0; i < N; i++) begin
            req_valid[i]             = pend[i];
            req_entry[i*EW +: EW]    = EW'(pe[i]);
            req_value[i*DW +: DW]    = pv[i];
        end
        @(negedge clk);
        g = -1;
        if (!f) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && m_full[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        for (int i = 0; i < N; i++) rdy[i] = !f && (!m_full[i] || g == i);
        check("req_ready", 64'(req_ready), 64'(rdy));
        nx = m_out;
        if (!r) begin
            for (int i = 0; i < N; i++) m_full[i] = 1'b0;
            m_ptr = 0;
            nx = '{w: 1'b0, e: '0, v: '0, s: '0};
        end else begin
            nx.w = (g >= 0);
            if (g >= 0) begin
                nx.e  = EW'(m_e[g]);
                nx.v  = m_v[g];
                nx.s  = 2'(g);
                m_ptr = (g + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (f) m_full[i] = 1'b0;
                else if (pend[i] && rdy[i]) begin
                    m_full[i] = 1'b1;
                    m_e[i]    = pe[i];
                    m_v[i]    = pv[i];
                end else if (g == i) m_full[i] = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) if (pend[i] && rdy[i]) pend[i] = 1'b0;
        m_out = nx;
        sb.push_back(nx);
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int i, input int e, input bit [DW-1:0] v);
        pend[i] = 1'b1;
        pe[i]   = e;
        pv[i]   = v;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) tick(1'b1, 1'b0);
    endtask

    // Monitor: one prediction per clock edge, compared well after the edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("cdb_write", 64'(cdb_write), 64'(x.w));
                check("cdb_entry", 64'(cdb_entry), 64'(x.e));
                check("cdb_value", 64'(cdb_value), 64'(x.v));
                check("cdb_src",   64'(cdb_src),   64'(x.s));
            end
        end
    end

    initial begin
        rst = 1'b0; flush = 1'b0;
        req_valid = '0; req_entry = '0; req_value = '0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; pe[i] = 0; pv[i] = '0;
            m_full[i] = 1'b0; m_e[i] = 0; m_v[i] = '0;
        end
        m_ptr = 0;
        m_out = '{w: 1'b0, e: '0, v: '0, s: '0};
        repeat (2) @(posedge clk);
        #1;
        check("reset_write", 64'(cdb_write), 64'd0);
        check("reset_entry", 64'(cdb_entry), 64'd0);
        check("reset_value", 64'(cdb_value), 64'd0);
        check("reset_src",   64'(cdb_src),   64'd0);
        check("reset_ready", 64'(req_ready), 64'hf);

        // Single request from unit 1.
        offer(1, 5, 32'h1234);
        idle(4);

        // All four continuously valid.
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < N; i++) if (!pend[i]) offer(i, i, $urandom);
            tick(1'b1, 1'b0);
        end
        idle(5);

        // Stalled slot: unit 2 keeps offering new data behind its buffered result.
        offer(0, 1, 32'hA0A0_0000);
        offer(2, 2, 32'hB0B0_0001);
        tick(1'b1, 1'b0);
        offer(2, 6, 32'hB0B0_0002);
        idle(6);

        // Flush with every slot full.
        for (int i = 0; i < N; i++) offer(i, 7 - i, $urandom);
        idle(1);
        for (int i = 0; i < N; i++) offer(i, i + 4, $urandom);
        idle(1);
        tick(1'b1, 1'b1);
        idle(6);

        // Reset while slots 1 and 3 are full and a broadcast is pending.
        offer(1, 3, 32'hDEAD_0001);
        offer(3, 4, 32'hDEAD_0003);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        idle(5);

        // Pointer wrap: slot 3 alone, then slots 0 and 3 together.
        offer(3, 2, 32'hC0DE_0003);
        idle(3);
        offer(0, 1, 32'hC0DE_0000);
        offer(3, 5, 32'hC0DE_0033);
        idle(4);

        // Randomized traffic with occasional flush and reset.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom % 2 == 0)) offer(i, int'($urandom % 8), $urandom);
            end
            tick($urandom_range(0, 99) != 0, $urandom_range(0, 99) < 3);
        end
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        idle(6);

        #10;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
